// File: rtl/nn_layer_sequencer_pkg.sv
// Shared widths, FSM state encodings and table-depth helper for the layer sequencer.
// Pure declarations; no logic, no latency, no flow control.
`timescale 1ns/1ps
package nn_layer_sequencer_pkg;

  localparam int DEF_LAYER_WIDTH = 3;
  localparam int DEF_DIM_WIDTH   = 8;
  localparam int DEF_ADDR_WIDTH  = 16;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_CHECK = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;
  localparam logic [2:0] ST_ERR   = 3'd5;

  function automatic int max_layers(input int layer_width);
    return 1 << layer_width;
  endfunction

endpackage

// File: rtl/nn_layer_sequencer_if.sv
// Control, shape-config and MAC-handshake bundle of the layer sequencer.
// master = controller/MAC side, slave = sequencer; mac_valid/mac_ready is the only backpressure.
`timescale 1ns/1ps
interface nn_layer_sequencer_if
  import nn_layer_sequencer_pkg::*;
#(
  parameter int LAYER_WIDTH = DEF_LAYER_WIDTH,
  parameter int DIM_WIDTH   = DEF_DIM_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
);

  logic                   cfg_we;
  logic [LAYER_WIDTH-1:0] cfg_addr;
  logic [DIM_WIDTH-1:0]   cfg_data;
  logic                   start;
  logic                   busy;
  logic                   done;
  logic                   err;
  logic                   mac_valid;
  logic                   mac_ready;
  logic [DIM_WIDTH-1:0]   weight_idx;
  logic [DIM_WIDTH-1:0]   node_idx;
  logic [LAYER_WIDTH-1:0] layer_idx;
  logic [ADDR_WIDTH-1:0]  weight_addr;
  logic                   node_last;
  logic                   layer_last;
  logic                   mem_select;

  modport master (
    output cfg_we, cfg_addr, cfg_data, start, mac_ready,
    input  busy, done, err, mac_valid, weight_idx, node_idx, layer_idx,
           weight_addr, node_last, layer_last, mem_select
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_data, start, mac_ready,
    output busy, done, err, mac_valid, weight_idx, node_idx, layer_idx,
           weight_addr, node_last, layer_last, mem_select
  );

endinterface

// File: rtl/nn_layer_sequencer_index_counter.sv
// Wrapping index counter: counts 0..limit-1 on en, returns to 0 on en & last; clear has priority.
// Count is registered (1-cycle update); holds whenever en is low, so it stalls with the caller.
`timescale 1ns/1ps
module nn_index_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  logic [WIDTH-1:0] count_q, count_d;

  // limit 0 underflows to all-ones, so an empty dimension never reports last
  assign last  = (count_q == (limit - 1'b1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en) begin
      count_d = last ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/nn_layer_sequencer.sv
// Walks weight/node/layer indices of a dense NN from a writable shape table; first MAC pair 2 cycles after start.
// Indices and weight_addr advance only on mac_valid & mac_ready; one bubble cycle between layers.
`timescale 1ns/1ps
module nn_layer_sequencer
  import nn_layer_sequencer_pkg::*;
#(
  parameter int LAYER_WIDTH = DEF_LAYER_WIDTH,
  parameter int DIM_WIDTH   = DEF_DIM_WIDTH,
  parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH
) (
  input  logic               clk,
  input  logic               reset_n,
  nn_layer_sequencer_if.slave bus
);

  localparam int MAX_LAYERS = max_layers(LAYER_WIDTH);

  logic [DIM_WIDTH-1:0]   shape_q [MAX_LAYERS];
  logic [2:0]             state_q, state_d;
  logic                   mac_valid_q, mac_valid_d;
  logic                   err_q, err_d;
  logic [LAYER_WIDTH-1:0] layer_q, layer_d;
  logic [ADDR_WIDTH-1:0]  addr_q, addr_d;

  logic                   busy;
  logic                   start_acc;
  logic                   step;
  logic                   w_last, n_last;
  logic [DIM_WIDTH-1:0]   w_cnt, n_cnt;
  logic [LAYER_WIDTH-1:0] layer_nxt;
  logic [LAYER_WIDTH:0]   layer_plus2;
  logic [LAYER_WIDTH-1:0] layer_p2_idx;
  logic                   final_layer;

  assign busy      = (state_q == ST_CHECK) || (state_q == ST_RUN) || (state_q == ST_GAP);
  assign start_acc = (state_q == ST_IDLE) && bus.start;
  assign step      = mac_valid_q && bus.mac_ready;

  assign layer_nxt    = layer_q + 1'b1;
  assign layer_plus2  = {1'b0, layer_q} + (LAYER_WIDTH+1)'(2);
  assign layer_p2_idx = layer_plus2[LAYER_WIDTH-1:0];
  // The last table slot is an implicit terminator; the wrapped index is masked by the first term
  assign final_layer  = (layer_plus2 == (LAYER_WIDTH+1)'(MAX_LAYERS)) ||
                        (shape_q[layer_p2_idx] == '0);

  // Table is writable whenever no inference is in flight, including the start cycle itself
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MAX_LAYERS; i++) begin
        shape_q[i] <= '0;
      end
    end else if (bus.cfg_we && !busy) begin
      shape_q[bus.cfg_addr] <= bus.cfg_data;
    end
  end

  nn_index_counter #(.WIDTH(DIM_WIDTH)) u_weight_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_acc),
    .en      (step),
    .limit   (shape_q[layer_q]),
    .count   (w_cnt),
    .last    (w_last)
  );

  nn_index_counter #(.WIDTH(DIM_WIDTH)) u_node_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .clear   (start_acc),
    .en      (step && w_last),
    .limit   (shape_q[layer_nxt]),
    .count   (n_cnt),
    .last    (n_last)
  );

  always_comb begin
    state_d     = state_q;
    mac_valid_d = mac_valid_q;
    err_d       = err_q;
    layer_d     = layer_q;
    addr_d      = addr_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_CHECK;
          err_d   = 1'b0;
          layer_d = '0;
          addr_d  = '0;
        end
      end
      ST_CHECK: begin
        if ((shape_q[0] == '0) || (shape_q[1] == '0)) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else begin
          state_d     = ST_RUN;
          mac_valid_d = 1'b1;
        end
      end
      ST_RUN: begin
        if (step) begin
          addr_d = addr_q + 1'b1;
          if (w_last && n_last) begin
            mac_valid_d = 1'b0;
            state_d     = final_layer ? ST_DONE : ST_GAP;
          end
        end
      end
      ST_GAP: begin
        layer_d     = layer_nxt;
        mac_valid_d = 1'b1;
        state_d     = ST_RUN;
      end
      ST_DONE:  state_d = ST_IDLE;
      ST_ERR:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mac_valid_q <= 1'b0;
      err_q       <= 1'b0;
      layer_q     <= '0;
      addr_q      <= '0;
    end else begin
      state_q     <= state_d;
      mac_valid_q <= mac_valid_d;
      err_q       <= err_d;
      layer_q     <= layer_d;
      addr_q      <= addr_d;
    end
  end

  assign bus.busy        = busy;
  assign bus.done        = (state_q == ST_DONE);
  assign bus.err         = err_q;
  assign bus.mac_valid   = mac_valid_q;
  assign bus.weight_idx  = w_cnt;
  assign bus.node_idx    = n_cnt;
  assign bus.layer_idx   = layer_q;
  assign bus.weight_addr = addr_q;
  assign bus.node_last   = mac_valid_q && w_last;
  assign bus.layer_last  = mac_valid_q && w_last && n_last;
  assign bus.mem_select  = layer_q[0];

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Bench for nn_layer_sequencer: table-driven shapes plus hand sequences for busy
// interference, same-cycle cfg/start and mid-run reset; MAC steps checked against a queued model.
`timescale 1ns/1ps
module tb_nn_layer_sequencer;
  import nn_layer_sequencer_pkg::*;

  typedef logic [7:0][7:0] shp_t;

  typedef struct {
    shp_t sh;
    bit   tog;
    bit   exp_err;
    int   exp_steps;
    int   exp_cycles;
    int   exp_toggles;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  nn_layer_sequencer_if bus ();

  nn_layer_sequencer dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int total;
  int bad;
  logic [37:0] exp_q [$];
  vec_t vecs [6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic shp_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    shp_t s;
    s[0] = 8'(a0); s[1] = 8'(a1); s[2] = 8'(a2); s[3] = 8'(a3);
    s[4] = 8'(a4); s[5] = 8'(a5); s[6] = 8'(a6); s[7] = 8'(a7);
    return s;
  endfunction

  function automatic logic [37:0] pack_rec(input int w, n, l, a, input bit nl, ll, ms);
    return {8'(w), 8'(n), 3'(l), 16'(a), nl, ll, ms};
  endfunction

  function automatic logic [37:0] dut_rec();
    return {bus.weight_idx, bus.node_idx, bus.layer_idx, bus.weight_addr,
            bus.node_last, bus.layer_last, bus.mem_select};
  endfunction

  function automatic logic [41:0] all_outs();
    return {bus.busy, bus.done, bus.err, bus.mac_valid, dut_rec()};
  endfunction

  // Expected MAC sequence: layer-major, then output node, then input weight
  task automatic build_model(input shp_t sh);
    int addr;
    bit nl;
    addr = 0;
    exp_q.delete();
    if (sh[0] != 0 && sh[1] != 0) begin
      for (int l = 0; l < 7 && sh[l+1] != 0; l++) begin
        for (int n = 0; n < int'(sh[l+1]); n++) begin
          for (int w = 0; w < int'(sh[l]); w++) begin
            nl = (w == int'(sh[l]) - 1);
            exp_q.push_back(pack_rec(w, n, l, addr, nl,
                                     nl && (n == int'(sh[l+1]) - 1), l[0]));
            addr++;
          end
        end
      end
    end
  endtask

  task automatic load_shape(input shp_t sh);
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = 3'(i);
      bus.cfg_data = sh[i];
    end
    @(posedge clk); #1;
    bus.cfg_we = 1'b0;
  endtask

  task automatic run_one(input int id, input shp_t model_sh, input bit tog, input bit exp_err,
                         input int exp_steps, input int exp_cycles, input int exp_toggles,
                         input bit inj, input bit cfg_with_start,
                         input logic [2:0] cs_addr, input logic [7:0] cs_data);
    int cyc, steps, toggles, done_cyc;
    bit prev_stall, rdy;
    logic prev_mem;
    logic [37:0] prev_rec;
    build_model(model_sh);
    @(posedge clk); #1;
    bus.start = 1'b1;
    if (cfg_with_start) begin
      bus.cfg_we   = 1'b1;
      bus.cfg_addr = cs_addr;
      bus.cfg_data = cs_data;
    end
    @(posedge clk); #1;
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    cyc = 1; steps = 0; toggles = 0; done_cyc = -1;
    prev_stall = 1'b0; prev_mem = 1'b0; prev_rec = '0;
    while (1) begin
      rdy = tog ? cyc[0] : 1'b1;
      bus.mac_ready = rdy;
      bus.cfg_we    = inj && (cyc == 5);
      bus.start     = inj && (cyc == 5);
      bus.cfg_addr  = 3'd1;
      bus.cfg_data  = 8'd7;
      #1;
      if (cyc == 1) begin
        chk($sformatf("v%0d busy_after_start", id), bus.busy, 1);
        prev_mem = bus.mem_select;
      end else if (bus.mem_select !== prev_mem) begin
        toggles++;
        prev_mem = bus.mem_select;
      end
      if (exp_err && cyc == 2) begin
        chk($sformatf("v%0d err_cycle2", id), bus.err, 1);
        chk($sformatf("v%0d busy_in_err", id), bus.busy, 0);
      end
      if (prev_stall) begin
        chk($sformatf("v%0d stall_hold", id), {bus.mac_valid, dut_rec()}, {1'b1, prev_rec});
      end
      prev_stall = bus.mac_valid && !rdy;
      prev_rec   = dut_rec();
      if (bus.mac_valid && rdy) begin
        steps++;
        if (exp_q.size() == 0) chk($sformatf("v%0d extra_step", id), 1, 0);
        else chk($sformatf("v%0d step%0d", id, steps), dut_rec(), exp_q.pop_front());
      end
      if (bus.done) begin
        done_cyc = cyc;
        chk($sformatf("v%0d busy_at_done", id), bus.busy, 0);
        break;
      end
      if (cyc >= (exp_err ? 6 : 2000)) break;
      @(posedge clk); #1;
      cyc++;
    end
    bus.cfg_we    = 1'b0;
    bus.start     = 1'b0;
    bus.mac_ready = 1'b1;
    chk($sformatf("v%0d done_seen", id), done_cyc >= 0, !exp_err);
    if (done_cyc >= 0) begin
      @(posedge clk); #1;
      chk($sformatf("v%0d done_one_cycle", id), {bus.done, bus.busy}, 2'b00);
    end
    chk($sformatf("v%0d steps", id), steps, exp_steps);
    chk($sformatf("v%0d model_drained", id), exp_q.size(), 0);
    chk($sformatf("v%0d err_final", id), bus.err, exp_err);
    chk($sformatf("v%0d final_addr", id), bus.weight_addr, exp_steps);
    chk($sformatf("v%0d mem_toggles", id), toggles, exp_toggles);
    if (exp_cycles > 0) chk($sformatf("v%0d total_cycles", id), done_cyc + 1, exp_cycles);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    shp_t sh432;
    total = 0;
    bad   = 0;
    reset_n       = 1'b0;
    bus.cfg_we    = 1'b0;
    bus.cfg_addr  = '0;
    bus.cfg_data  = '0;
    bus.start     = 1'b0;
    bus.mac_ready = 1'b1;
    sh432 = mk(4, 3, 2, 0, 0, 0, 0, 0);

    vecs[0] = '{sh432,                      1'b0, 1'b0, 18, 22, 1};
    vecs[1] = '{sh432,                      1'b1, 1'b0, 18,  0, 1};
    vecs[2] = '{mk(0, 3, 2, 0, 0, 0, 0, 0), 1'b0, 1'b1,  0,  0, 0};
    vecs[3] = '{mk(5, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1,  0,  0, 0};
    vecs[4] = '{mk(2, 2, 2, 2, 2, 2, 2, 2), 1'b0, 1'b0, 28, 37, 6};
    vecs[5] = '{mk(1, 1, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0,  2,  6, 1};

    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", all_outs(), '0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_reset", all_outs(), '0);

    for (int i = 0; i < 6; i++) begin
      load_shape(vecs[i].sh);
      run_one(i, vecs[i].sh, vecs[i].tog, vecs[i].exp_err, vecs[i].exp_steps,
              vecs[i].exp_cycles, vecs[i].exp_toggles, 1'b0, 1'b0, 3'd0, 8'd0);
    end

    // cfg write and start while busy must be ignored, and the table must survive
    load_shape(sh432);
    run_one(10, sh432, 1'b0, 1'b0, 18, 22, 1, 1'b1, 1'b0, 3'd0, 8'd0);
    run_one(11, sh432, 1'b0, 1'b0, 18, 22, 1, 1'b0, 1'b0, 3'd0, 8'd0);

    // cfg write in the start cycle lands before the shape check
    load_shape(sh432);
    run_one(12, mk(4, 1, 2, 0, 0, 0, 0, 0), 1'b0, 1'b0, 6, 10, 1, 1'b0, 1'b1, 3'd1, 8'd1);

    // asynchronous reset in the middle of layer 1 also wipes the table
    load_shape(sh432);
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    k = 0;
    while (!(bus.layer_idx == 3'd1 && bus.mac_valid) && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_layer1", k < 100, 1);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_outputs", all_outs(), '0);
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b1;
    run_one(13, mk(0, 0, 0, 0, 0, 0, 0, 0), 1'b0, 1'b1, 0, 0, 0, 1'b0, 1'b0, 3'd0, 8'd0);
    load_shape(sh432);
    run_one(14, sh432, 1'b0, 1'b0, 18, 22, 1, 1'b0, 1'b0, 3'd0, 8'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
